// File: rtl/prim_ram_2p_sync.sv
// Single-clock two-port RAM with grouped write masks, 1/2-cycle qualified reads,
// read-first/write-first selection, port-A-wins write merging and a post-reset clear sweep.

module prim_ram_2p_sync_rdpipe #(
  parameter int Width       = 32,
  parameter int ReadLatency = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             vld_i,
  input  logic [Width-1:0] data_i,
  output logic             vld_o,
  output logic [Width-1:0] data_o
);
  logic [ReadLatency:1]            vld_pipe_q;
  logic [ReadLatency:1][Width-1:0] data_pipe_q;

  // Data registers only load on a valid beat so rdata holds between pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe_q  <= '0;
      data_pipe_q <= '0;
    end else begin
      vld_pipe_q[1] <= vld_i;
      if (vld_i) data_pipe_q[1] <= data_i;
      for (int s = 2; s <= ReadLatency; s++) begin
        vld_pipe_q[s] <= vld_pipe_q[s-1];
        if (vld_pipe_q[s-1]) data_pipe_q[s] <= data_pipe_q[s-1];
      end
    end
  end

  assign vld_o  = vld_pipe_q[ReadLatency];
  assign data_o = data_pipe_q[ReadLatency];
endmodule

module prim_ram_2p_sync #(
  parameter int    Width           = 32,
  parameter int    Depth           = 128,
  parameter int    DataBitsPerMask = 1,
  parameter int    ReadLatency     = 1,
  parameter int    WriteFirst      = 0,
  parameter int    ClearOnReset    = 1,
  parameter string MemInitFile     = "",
  localparam int   Aw              = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             a_req_i,
  input  logic             a_write_i,
  input  logic [Aw-1:0]    a_addr_i,
  input  logic [Width-1:0] a_wdata_i,
  input  logic [Width-1:0] a_wmask_i,
  output logic [Width-1:0] a_rdata_o,
  output logic             a_rvalid_o,
  input  logic             b_req_i,
  input  logic             b_write_i,
  input  logic [Aw-1:0]    b_addr_i,
  input  logic [Width-1:0] b_wdata_i,
  input  logic [Width-1:0] b_wmask_i,
  output logic [Width-1:0] b_rdata_o,
  output logic             b_rvalid_o,
  output logic             init_done_o,
  output logic             collision_o
);
  localparam int NumGrp = Width / DataBitsPerMask;
  localparam int Dbm    = DataBitsPerMask;

  typedef struct packed {
    logic              req;
    logic              write;
    logic [Aw-1:0]     addr;
    logic [Width-1:0]  wdata;
    logic [NumGrp-1:0] gmask;
  } port_req_t;

  typedef enum logic {StClear, StReady} state_e;

  port_req_t [1:0]            preq;
  logic      [1:0]            acc, we;
  logic      [1:0][Width-1:0] wf_word, rd_word, rdata;
  logic      [1:0]            rvalid;

  state_e        state_q, state_d;
  logic [Aw-1:0] clr_cnt_q, clr_cnt_d;
  logic          clr_we;
  logic          collision_q, collision_d;

  logic [Width-1:0] mem_q [Depth];

  // Port 0 is A, port 1 is B; a mask group counts only when every bit in it is set.
  always_comb begin
    preq[0].req   = a_req_i;
    preq[0].write = a_write_i;
    preq[0].addr  = a_addr_i;
    preq[0].wdata = a_wdata_i;
    preq[1].req   = b_req_i;
    preq[1].write = b_write_i;
    preq[1].addr  = b_addr_i;
    preq[1].wdata = b_wdata_i;
    for (int g = 0; g < NumGrp; g++) begin
      preq[0].gmask[g] = &a_wmask_i[g*Dbm +: Dbm];
      preq[1].gmask[g] = &b_wmask_i[g*Dbm +: Dbm];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= (ClearOnReset != 0) ? StClear : StReady;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == StClear) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == Aw'(Depth - 1)) state_d = StReady;
    end
  end

  always_comb begin
    init_done_o = (state_q == StReady);
    clr_we      = (state_q == StClear) && !rst_i;
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      acc[p] = preq[p].req & init_done_o & ~rst_i;
      we[p]  = acc[p] & preq[p].write;
    end
  end

  // Post-edge view of each read address: B's groups first, then A's on top.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      wf_word[p] = mem_q[preq[p].addr];
      for (int q = 1; q >= 0; q--) begin
        for (int g = 0; g < NumGrp; g++) begin
          if (we[q] && preq[q].addr == preq[p].addr && preq[q].gmask[g])
            wf_word[p][g*Dbm +: Dbm] = preq[q].wdata[g*Dbm +: Dbm];
        end
      end
      rd_word[p] = (WriteFirst != 0) ? wf_word[p] : mem_q[preq[p].addr];
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_we) mem_q[clr_cnt_q] <= '0;
    for (int g = 0; g < NumGrp; g++) begin
      if (we[0] && preq[0].gmask[g])
        mem_q[preq[0].addr][g*Dbm +: Dbm] <= preq[0].wdata[g*Dbm +: Dbm];
      if (we[1] && preq[1].gmask[g] &&
          !(we[0] && preq[0].gmask[g] && preq[0].addr == preq[1].addr))
        mem_q[preq[1].addr][g*Dbm +: Dbm] <= preq[1].wdata[g*Dbm +: Dbm];
    end
  end

  assign collision_d = we[0] & we[1] & (preq[0].addr == preq[1].addr) &
                       |(preq[0].gmask & preq[1].gmask);

  always_ff @(posedge clk_i) begin
    if (rst_i) collision_q <= 1'b0;
    else       collision_q <= collision_d;
  end

  prim_ram_2p_sync_rdpipe #(
    .Width       (Width),
    .ReadLatency (ReadLatency)
  ) u_rdpipe [1:0] (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .vld_i  (acc),
    .data_i (rd_word),
    .vld_o  (rvalid),
    .data_o (rdata)
  );

  assign a_rdata_o   = rdata[0];
  assign b_rdata_o   = rdata[1];
  assign a_rvalid_o  = rvalid[0];
  assign b_rvalid_o  = rvalid[1];
  assign collision_o = collision_q;
endmodule

// File: tb/tb_prim_ram_2p_sync.sv
// Randomized scoreboard bench for prim_ram_2p_sync (Depth 8, byte masks, 2-cycle read, write-first).

module tb_prim_ram_2p_sync;
  localparam int W = 32, D = 8, G = 8, RL = 2, WF = 1, COR = 1, AW = 3;

  logic          clk = 1'b0, rst;
  logic          a_req, a_write, b_req, b_write;
  logic [AW-1:0] a_addr, b_addr;
  logic [W-1:0]  a_wdata, a_wmask, b_wdata, b_wmask;
  logic [W-1:0]  a_rdata, b_rdata;
  logic          a_rvalid, b_rvalid, init_done, collision;

  prim_ram_2p_sync #(
    .Width(W), .Depth(D), .DataBitsPerMask(G), .ReadLatency(RL),
    .WriteFirst(WF), .ClearOnReset(COR), .MemInitFile("")
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_write_i(a_write), .a_addr_i(a_addr),
    .a_wdata_i(a_wdata), .a_wmask_i(a_wmask), .a_rdata_o(a_rdata), .a_rvalid_o(a_rvalid),
    .b_req_i(b_req), .b_write_i(b_write), .b_addr_i(b_addr),
    .b_wdata_i(b_wdata), .b_wmask_i(b_wmask), .b_rdata_o(b_rdata), .b_rvalid_o(b_rvalid),
    .init_done_o(init_done), .collision_o(collision)
  );

  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  typedef struct { logic [W-1:0] data; int due; } exp_t;
  exp_t         q [2][$];
  logic [W-1:0] model [D];
  bit           ready_m, clearing_m;
  int           clr_m;
  bit           exp_init [int], exp_coll [int], exp_rst [int];
  logic [W-1:0] last [2];
  int           tests = 0, fails = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, ecnt);
    end
  endtask

  function automatic bit full_grp(logic [W-1:0] m, int g);
    return &m[g*G +: G];
  endfunction

  // Reference: what the edge about to happen does, from the documented rules.
  task automatic model_edge();
    int           e = ecnt + 1;
    logic [W-1:0] nm [D];
    bit           aa, ba, coll;
    exp_t         x;
    if (rst) begin
      clearing_m = (COR != 0); clr_m = 0; ready_m = (COR == 0);
      for (int p = 0; p < 2; p++)
        while (q[p].size() > 0 && q[p][$].due > ecnt) void'(q[p].pop_back());
      exp_init[e] = (COR == 0); exp_coll[e] = 0; exp_rst[e] = 1;
      return;
    end
    exp_rst[e] = 0;
    aa = a_req && ready_m;
    ba = b_req && ready_m;
    nm = model;
    coll = 0;
    if (clearing_m) nm[clr_m] = '0;
    if (ba && b_write)
      for (int g = 0; g < W/G; g++)
        if (full_grp(b_wmask, g)) nm[b_addr][g*G +: G] = b_wdata[g*G +: G];
    if (aa && a_write)
      for (int g = 0; g < W/G; g++)
        if (full_grp(a_wmask, g)) begin
          nm[a_addr][g*G +: G] = a_wdata[g*G +: G];
          if (ba && b_write && b_addr == a_addr && full_grp(b_wmask, g)) coll = 1;
        end
    x.due = ecnt + RL;
    if (aa) begin x.data = (WF != 0) ? nm[a_addr] : model[a_addr]; q[0].push_back(x); end
    if (ba) begin x.data = (WF != 0) ? nm[b_addr] : model[b_addr]; q[1].push_back(x); end
    model = nm;
    if (clearing_m) begin
      clr_m++;
      if (clr_m == D) begin clearing_m = 0; ready_m = 1; end
    end
    exp_init[e] = ready_m;
    exp_coll[e] = coll;
  endtask

  always @(negedge clk) begin
    if (ecnt > 0) begin
      chk("init_done", init_done, exp_init[ecnt]);
      chk("collision", collision, exp_coll[ecnt]);
      if (exp_rst[ecnt]) begin
        chk("rst_a_rvalid", a_rvalid, 0); chk("rst_b_rvalid", b_rvalid, 0);
        chk("rst_a_rdata", a_rdata, 0);   chk("rst_b_rdata", b_rdata, 0);
        last[0] = '0; last[1] = '0;
      end else begin
        for (int p = 0; p < 2; p++) begin
          logic         rv;
          logic [W-1:0] rd;
          bit           hit;
          exp_t         x;
          rv  = p ? b_rvalid : a_rvalid;
          rd  = p ? b_rdata  : a_rdata;
          hit = q[p].size() > 0 && q[p][0].due == ecnt;
          chk(p ? "b_rvalid" : "a_rvalid", rv, hit);
          if (hit) begin
            x = q[p].pop_front();
            chk(p ? "b_rdata" : "a_rdata", rd, x.data);
          end else if (!rv) begin
            chk(p ? "b_rdata_hold" : "a_rdata_hold", rd, last[p]);
          end
          last[p] = rd;
        end
      end
    end
  end

  task automatic cyc(bit r, bit ar, bit aw, int aad, logic [W-1:0] ad, logic [W-1:0] am,
                     bit br, bit bw, int bad, logic [W-1:0] bd, logic [W-1:0] bm);
    rst = r;
    a_req = ar; a_write = aw; a_addr = AW'(aad); a_wdata = ad; a_wmask = am;
    b_req = br; b_write = bw; b_addr = AW'(bad); b_wdata = bd; b_wmask = bm;
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(int n, bit r);
    for (int i = 0; i < n; i++) cyc(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [W-1:0] rnd_mask();
    logic [W-1:0] m;
    for (int g = 0; g < W/G; g++)
      case ($urandom_range(0, 3))
        0:       m[g*G +: G] = '0;
        1:       m[g*G +: G] = G'($urandom);
        default: m[g*G +: G] = '1;
      endcase
    return m;
  endfunction

  task automatic rnd_cyc(bit narrow);
    int hi = narrow ? 1 : D - 1;
    cyc(0, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, hi),
        $urandom, rnd_mask(),
        $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, hi),
        $urandom, rnd_mask());
  endtask

  initial begin
    last[0] = '0; last[1] = '0;
    idle(2, 1);
    // requests while clearing must be dropped
    cyc(0, 1, 1, 7, 32'hDEADBEEF, '1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) rnd_cyc(0);
    idle(4, 0);
    cyc(0, 1, 0, 5, 0, 0, 1, 0, 7, 0, 0);
    idle(3, 0);
    cyc(0, 1, 1, 3, 32'h11111111, '1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 3, 32'h22222222, '1, 1, 0, 3, 0, 0);
    idle(3, 0);
    cyc(0, 1, 1, 2, 32'hAAAAAAAA, 32'h0000FFFF, 1, 1, 2, 32'hBBBBBBBB, 32'h00FFFFFF);
    cyc(0, 1, 0, 2, 0, 0, 1, 0, 2, 0, 0);
    idle(3, 0);
    for (int i = 0; i < D; i++) cyc(0, 1, 0, i, 0, 0, 0, 0, 0, 0, 0);
    idle(3, 0);
    for (int i = 0; i < 1500; i++) rnd_cyc(i % 2 == 0);
    // reset with reads in flight, then recover through a full clear
    cyc(0, 1, 0, 1, 0, 0, 1, 0, 2, 0, 0);
    cyc(0, 1, 0, 3, 0, 0, 1, 0, 4, 0, 0);
    idle(2, 1);
    for (int i = 0; i < 200; i++) rnd_cyc(0);
    // reset in the middle of the clear sweep
    for (int i = 0; i < 150; i++) rnd_cyc(1);
    idle(1, 1);
    for (int i = 0; i < 3; i++) rnd_cyc(0);
    idle(1, 1);
    for (int i = 0; i < 300; i++) rnd_cyc(i % 3 == 0);
    for (int i = 0; i < D; i++) cyc(0, 1, 0, i, 0, 0, 1, 0, D - 1 - i, 0, 0);
    idle(5, 0);
    chk("drain_a", q[0].size(), 0);
    chk("drain_b", q[1].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
